instr_prefetch_ir: RTL and testbench

Parametrised successor to the single-entry instruction register. It is a DEPTH-entry prefetch queue between instruction memory and the decode stage, with valid/ready handshakes on both sides. Each instruction word is split into opcode, destination-register and immediate fields. The block adds a synchronous flush for branches and an optional sign-extension of the immediate field.

---
 rtl/instr_prefetch_ir_if.sv | 35 +++
 rtl/instr_prefetch_ir.sv | 75 +++++++
 tb/tb_instr_prefetch_ir.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/instr_prefetch_ir_if.sv
// Handshake bundle between the fetch side, the prefetch queue and the decode stage.
// The queue takes the slave view; whoever drives fetch and decode takes the master view.
interface instr_prefetch_ir_if #(
  parameter int OPC_W  = 4,
  parameter int RZ_W   = 4,
  parameter int IMM_W  = 16,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
);
  localparam int INSTR_W = OPC_W + RZ_W + IMM_W;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] instr_in;
  logic               flush;
  logic               sext_en;
  logic               out_valid;
  logic               out_ready;
  logic [OPC_W-1:0]   opcode;
  logic [RZ_W-1:0]    addr_Rz;
  logic [IMM_W-1:0]   src_imm;
  logic [DATA_W-1:0]  imm_ext;
  logic [CNT_W-1:0]   count;

  modport master (
    output in_valid, instr_in, flush, sext_en, out_ready,
    input  in_ready, out_valid, opcode, addr_Rz, src_imm, imm_ext, count
  );

  modport slave (
    input  in_valid, instr_in, flush, sext_en, out_ready,
    output in_ready, out_valid, opcode, addr_Rz, src_imm, imm_ext, count
  );
endinterface

// File: rtl/instr_prefetch_ir.sv
// DEPTH-entry instruction prefetch queue that decodes the head word into opcode,
// destination register and immediate fields, with a branch flush.
module instr_prefetch_ir #(
  parameter int OPC_W  = 4,
  parameter int RZ_W   = 4,
  parameter int IMM_W  = 16,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input logic clk,
  input logic reset,
  instr_prefetch_ir_if.slave bus
);
  localparam int INSTR_W = OPC_W + RZ_W + IMM_W;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;

  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               doPush, doPop;
  logic [INSTR_W-1:0] headWord;

  // Handshake flags come only from registered occupancy, so out_ready never reaches in_ready.
  assign bus.in_ready  = (count_q != CNT_W'(DEPTH));
  assign bus.out_valid = (count_q != '0);
  assign bus.count     = count_q;
  assign doPush        = bus.in_valid && bus.in_ready;
  assign doPop         = bus.out_valid && bus.out_ready;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (bus.flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (doPush) wrPtr_d = wrPtr_q + PTR_W'(1);
      if (doPop)  rdPtr_d = rdPtr_q + PTR_W'(1);
      if (doPush && !doPop)      count_d = count_q + CNT_W'(1);
      else if (!doPush && doPop) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage is left unreset; an empty queue masks whatever it holds.
  always_ff @(posedge clk) begin
    if (doPush && !bus.flush) mem_q[wrPtr_q] <= bus.instr_in;
  end

  assign headWord    = bus.out_valid ? mem_q[rdPtr_q] : '0;
  assign bus.opcode  = headWord[INSTR_W-1 -: OPC_W];
  assign bus.addr_Rz = headWord[IMM_W +: RZ_W];
  assign bus.src_imm = headWord[IMM_W-1:0];

  if (DATA_W > IMM_W) begin : gExt
    assign bus.imm_ext = {{(DATA_W-IMM_W){bus.sext_en & headWord[IMM_W-1]}}, headWord[IMM_W-1:0]};
  end else begin : gNoExt
    assign bus.imm_ext = headWord[IMM_W-1:0];
  end
endmodule

// File: tb/tb_instr_prefetch_ir.sv
// Bench for instr_prefetch_ir: vector table, scoreboard monitor and hand-written
// corner sequences, driving a 16-bit and a 32-bit immediate instance in lockstep.
module tb_instr_prefetch_ir;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic        iv;
    logic        orr;
    logic        fl;
    logic        sx;
    logic [23:0] word;
    logic [2:0]  cnt;
    logic        ov;
    logic        ir;
    logic [23:0] head;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;
  logic [23:0] sbQueue [$];
  vec_t vecs [21];

  instr_prefetch_ir_if #(.DATA_W(16), .DEPTH(DEPTH)) bus16 ();
  instr_prefetch_ir_if #(.DATA_W(32), .DEPTH(DEPTH)) bus32 ();

  instr_prefetch_ir #(.DATA_W(16), .DEPTH(DEPTH)) dut16 (.clk(clk), .reset(reset), .bus(bus16));
  instr_prefetch_ir #(.DATA_W(32), .DEPTH(DEPTH)) dut32 (.clk(clk), .reset(reset), .bus(bus32));

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic orr, input logic fl, input logic sx,
                               input logic [23:0] word);
    bus16.in_valid = iv;  bus32.in_valid = iv;
    bus16.out_ready = orr; bus32.out_ready = orr;
    bus16.flush = fl;     bus32.flush = fl;
    bus16.sext_en = sx;   bus32.sext_en = sx;
    bus16.instr_in = word; bus32.instr_in = word;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mkVec(input logic iv, input logic orr, input logic fl, input logic sx,
                                 input logic [23:0] word, input logic [2:0] cnt, input logic ov,
                                 input logic ir, input logic [23:0] head);
    vec_t v;
    v.iv = iv; v.orr = orr; v.fl = fl; v.sx = sx; v.word = word;
    v.cnt = cnt; v.ov = ov; v.ir = ir; v.head = head;
    return v;
  endfunction

  // Independent queue model: checks the handshake flags and the popped head against pushed words.
  always @(posedge clk) begin
    logic [23:0] expWord;
    int modelSize;
    if (!reset) begin
      modelSize = sbQueue.size();
      checkOutput("sb_in_ready", 32'(bus16.in_ready), 32'(modelSize != DEPTH));
      checkOutput("sb_out_valid", 32'(bus16.out_valid), 32'(modelSize != 0));
      checkOutput("sb_count", 32'(bus16.count), 32'(modelSize));
      if (bus16.flush) begin
        sbQueue.delete();
      end else begin
        if (modelSize != 0 && bus16.out_ready) begin
          expWord = sbQueue.pop_front();
          checkOutput("sb_opcode", 32'(bus16.opcode), 32'(expWord[23:20]));
          checkOutput("sb_addr_Rz", 32'(bus16.addr_Rz), 32'(expWord[19:16]));
          checkOutput("sb_src_imm", 32'(bus16.src_imm), 32'(expWord[15:0]));
        end
        if (modelSize != DEPTH && bus16.in_valid) sbQueue.push_back(bus16.instr_in);
      end
    end
  end

  always @(posedge reset) sbQueue.delete();

  always @(negedge clk) begin
    if (!reset) begin
      checkOutput("count_range", 32'(bus16.count <= DEPTH), 32'd1);
      checkOutput("valid_vs_count", 32'(bus16.out_valid), 32'(bus16.count != 0));
    end
  end

  task automatic checkHead(input string tag, input logic [23:0] head, input logic sx);
    logic [31:0] ext32;
    ext32 = {{16{sx & head[15]}}, head[15:0]};
    checkOutput({tag, "_opcode"}, 32'(bus16.opcode), 32'(head[23:20]));
    checkOutput({tag, "_addr_Rz"}, 32'(bus16.addr_Rz), 32'(head[19:16]));
    checkOutput({tag, "_src_imm"}, 32'(bus16.src_imm), 32'(head[15:0]));
    checkOutput({tag, "_imm_ext16"}, 32'(bus16.imm_ext), 32'(head[15:0]));
    checkOutput({tag, "_imm_ext32"}, bus32.imm_ext, ext32);
  endtask

  initial begin
    logic [23:0] word;

    vecs[0]  = mkVec(1, 0, 0, 0, 24'h3A1234, 1, 1, 1, 24'h3A1234);
    vecs[1]  = mkVec(0, 0, 0, 1, 24'h000000, 1, 1, 1, 24'h3A1234);
    vecs[2]  = mkVec(0, 0, 0, 0, 24'h000000, 1, 1, 1, 24'h3A1234);
    vecs[3]  = mkVec(0, 0, 0, 1, 24'h000000, 1, 1, 1, 24'h3A1234);
    vecs[4]  = mkVec(0, 0, 0, 0, 24'h000000, 1, 1, 1, 24'h3A1234);
    vecs[5]  = mkVec(0, 0, 0, 1, 24'h000000, 1, 1, 1, 24'h3A1234);
    vecs[6]  = mkVec(1, 1, 0, 0, 24'h100001, 1, 1, 1, 24'h100001);
    vecs[7]  = mkVec(1, 0, 0, 0, 24'h200002, 2, 1, 1, 24'h100001);
    vecs[8]  = mkVec(1, 0, 0, 0, 24'h300003, 3, 1, 1, 24'h100001);
    vecs[9]  = mkVec(1, 0, 0, 0, 24'h400004, 4, 1, 0, 24'h100001);
    vecs[10] = mkVec(1, 0, 0, 0, 24'h500005, 4, 1, 0, 24'h100001);
    vecs[11] = mkVec(1, 1, 0, 0, 24'h600006, 3, 1, 1, 24'h200002);
    vecs[12] = mkVec(0, 1, 0, 0, 24'h000000, 2, 1, 1, 24'h300003);
    vecs[13] = mkVec(0, 1, 0, 0, 24'h000000, 1, 1, 1, 24'h400004);
    vecs[14] = mkVec(0, 1, 0, 0, 24'h000000, 0, 0, 1, 24'h000000);
    vecs[15] = mkVec(1, 0, 0, 0, 24'hA00010, 1, 1, 1, 24'hA00010);
    vecs[16] = mkVec(1, 0, 0, 0, 24'hB00011, 2, 1, 1, 24'hA00010);
    vecs[17] = mkVec(1, 0, 0, 0, 24'hC00012, 3, 1, 1, 24'hA00010);
    vecs[18] = mkVec(1, 1, 1, 0, 24'hD00013, 0, 0, 1, 24'h000000);
    vecs[19] = mkVec(1, 0, 0, 0, 24'hE00014, 1, 1, 1, 24'hE00014);
    vecs[20] = mkVec(0, 1, 0, 0, 24'h000000, 0, 0, 1, 24'h000000);

    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 24'h0);
    #2;
    checkOutput("rst_out_valid", 32'(bus16.out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(bus16.in_ready), 32'd1);
    checkOutput("rst_count", 32'(bus16.count), 32'd0);
    checkHead("rst", 24'h0, 1'b0);
    step();
    reset = 1'b0;

    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i].iv, vecs[i].orr, vecs[i].fl, vecs[i].sx, vecs[i].word);
      step();
      checkOutput($sformatf("vec%0d_count", i), 32'(bus16.count), 32'(vecs[i].cnt));
      checkOutput($sformatf("vec%0d_out_valid", i), 32'(bus16.out_valid), 32'(vecs[i].ov));
      checkOutput($sformatf("vec%0d_in_ready", i), 32'(bus16.in_ready), 32'(vecs[i].ir));
      checkHead($sformatf("vec%0d", i), vecs[i].head, vecs[i].sx);
    end

    // Streaming with both sides always ready wraps the pointers several times at occupancy 1.
    for (int i = 0; i < 20; i++) begin
      word = {4'(i), 4'(i + 3), 16'($urandom)};
      applyStimulus(1, 1, 0, 0, word);
      step();
      checkOutput($sformatf("stream%0d_count", i), 32'(bus16.count), 32'd1);
    end
    applyStimulus(0, 1, 0, 0, 24'h0);
    step();
    checkOutput("stream_drained", 32'(bus16.count), 32'd0);

    applyStimulus(1, 0, 0, 1, 24'h128001);
    step();
    applyStimulus(0, 0, 0, 1, 24'h0);
    #1;
    checkOutput("sext16", 32'(bus16.imm_ext), 32'h00008001);
    checkOutput("sext32", bus32.imm_ext, 32'hFFFF8001);
    applyStimulus(0, 0, 0, 0, 24'h0);
    #1;
    checkOutput("zext16", 32'(bus16.imm_ext), 32'h00008001);
    checkOutput("zext32", bus32.imm_ext, 32'h00008001);

    applyStimulus(1, 0, 0, 0, 24'h2C7FFF);
    step();
    applyStimulus(0, 0, 0, 0, 24'h0);
    checkOutput("pre_reset_count", 32'(bus16.count), 32'd2);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_rst_valid16", 32'(bus16.out_valid), 32'd0);
    checkOutput("async_rst_count16", 32'(bus16.count), 32'd0);
    checkOutput("async_rst_valid32", 32'(bus32.out_valid), 32'd0);
    checkOutput("async_rst_count32", 32'(bus32.count), 32'd0);
    step();
    reset = 1'b0;

    applyStimulus(1, 0, 0, 0, 24'h5B0F0F);
    step();
    checkOutput("post_rst_count", 32'(bus16.count), 32'd1);
    checkHead("post_rst", 24'h5B0F0F, 1'b0);
    applyStimulus(0, 1, 0, 0, 24'h0);
    step();
    checkOutput("final_count", 32'(bus16.count), 32'd0);
    checkHead("final", 24'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
